// File: rtl/mc_ctrl_unit_if.sv
// Control/status bundle between the multi-cycle MIPS controller and its datapath.
// The master modport belongs to the controller; the slave modport belongs to the datapath side.
interface mc_ctrl_unit_if;
  // Status from the datapath
  logic [31:0] Inst;
  logic        zero;
  logic        overflow;
  logic        MIO_ready;
  // Datapath controls and bus strobes
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic [1:0]  ALUSrcA;
  logic [2:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;
  logic [2:0]  ALU_operation;
  logic        MemRead;
  logic        MemWrite;
  logic        CPU_MIO;
  logic [4:0]  state;
  logic        exc;

  modport master (
    input  Inst, zero, overflow, MIO_ready,
    output IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
           PCWrite, PCWriteCond, Branch, ALU_operation, MemRead, MemWrite, CPU_MIO,
           state, exc
  );

  modport slave (
    output Inst, zero, overflow, MIO_ready,
    input  IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
           PCWrite, PCWriteCond, Branch, ALU_operation, MemRead, MemWrite, CPU_MIO,
           state, exc
  );
endinterface

// File: rtl/mc_ctrl_unit.sv
// Moore FSM sequencing a multi-cycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Every bus access (IF, MEM_RD, MEM_WR) stalls while MIO_ready is low.
// Optional feature: define OVERFLOW_TRAP_EN to suppress the writeback of an overflowing
// add/sub/addi and raise exc for that writeback cycle; otherwise exc is tied low.
module mc_ctrl_unit #(
  parameter int unsigned ST_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  mc_ctrl_unit_if.master bus
);

  typedef enum logic [ST_W-1:0] {
    StIf, StId, StExR, StExMa, StMemRd, StMemWr, StWbLw, StWbR,
    StExI, StWbI, StExLui, StExBeq, StExBne, StExJ, StExJal, StExJr
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpSlti  = 6'b001010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnJr  = 6'b001000;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluXor = 3'b011;
  localparam logic [2:0] AluNor = 3'b100;
  localparam logic [2:0] AluSrl = 3'b101;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e     state_q, state_d;
  logic [5:0] opcode, funct;
  logic       ready;

  logic       iord, ir_write, reg_write, pc_write, pc_write_cond, branch;
  logic       mem_read, mem_write, cpu_mio, exc;
  logic [1:0] reg_dst, mem_to_reg, alu_src_a, pc_source;
  logic [2:0] alu_src_b, alu_op;

  assign opcode = bus.Inst[31:26];
  assign funct  = bus.Inst[5:0];
  assign ready  = bus.MIO_ready;

  // zero is consumed by the datapath's branch gate; the middle IR fields are datapath-only
  logic unused_inputs;
  assign unused_inputs = ^{bus.zero, bus.overflow, bus.Inst[25:6]};

  // R-type funct to ALU operation; unknown functs fall back to ADD
  function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
    logic [2:0] op;
    op = AluAdd;
    case (fn)
      FnSub:   op = AluSub;
      FnAnd:   op = AluAnd;
      FnOr:    op = AluOr;
      FnXor:   op = AluXor;
      FnNor:   op = AluNor;
      FnSlt:   op = AluSlt;
      FnSrl:   op = AluSrl;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

  // Immediate-format opcode to ALU operation
  function automatic logic [2:0] i_alu_op(input logic [5:0] op_code);
    logic [2:0] op;
    op = AluAdd;
    case (op_code)
      OpAndi:  op = AluAnd;
      OpOri:   op = AluOr;
      OpXori:  op = AluXor;
      OpSlti:  op = AluSlt;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

`ifdef OVERFLOW_TRAP_EN
  logic ovf_q;

  // Remember whether the trapping arithmetic just executed overflowed; clear on every fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == StIf) begin
      ovf_q <= 1'b0;
    end else if (state_q == StExR && (funct == FnAdd || funct == FnSub)) begin
      ovf_q <= bus.overflow;
    end else if (state_q == StExI && opcode == OpAddi) begin
      ovf_q <= bus.overflow;
    end
  end
`else
  logic ovf_q;
  assign ovf_q = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d       = state_q;
    iord          = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'd0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'd0;
    alu_src_a     = 2'd0;
    alu_src_b     = 3'd0;
    pc_source     = 2'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch        = 1'b0;
    alu_op        = AluAnd;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    cpu_mio       = 1'b0;
    exc           = 1'b0;

    unique case (state_q)
      StIf: begin
        mem_read  = 1'b1;
        cpu_mio   = 1'b1;
        alu_src_b = 3'd1;
        alu_op    = AluAdd;
        // A stalled fetch must leave PC and IR untouched
        ir_write  = ready;
        pc_write  = ready;
        if (ready) state_d = StId;
      end
      StId: begin
        // Precompute the branch target into ALUOut while decoding
        alu_src_b = 3'd4;
        alu_op    = AluAdd;
        case (opcode)
          OpRtype:                             state_d = (funct == FnJr) ? StExJr : StExR;
          OpLw, OpSw:                          state_d = StExMa;
          OpBeq:                               state_d = StExBeq;
          OpBne:                               state_d = StExBne;
          OpJ:                                 state_d = StExJ;
          OpJal:                               state_d = StExJal;
          OpLui:                               state_d = StExLui;
          OpAddi, OpAndi, OpOri, OpXori, OpSlti: state_d = StExI;
          default:                             state_d = StIf;
        endcase
      end
      StExR: begin
        alu_src_a = 2'd1;
        alu_src_b = 3'd0;
        alu_op    = r_alu_op(funct);
        state_d   = StWbR;
      end
      StWbR: begin
        reg_dst   = 2'd1;
        reg_write = ~ovf_q;
        exc       = ovf_q;
        state_d   = StIf;
      end
      StExMa: begin
        alu_src_a = 2'd1;
        alu_src_b = 3'd2;
        alu_op    = AluAdd;
        state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        cpu_mio  = 1'b1;
        if (ready) state_d = StWbLw;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        cpu_mio   = 1'b1;
        if (ready) state_d = StIf;
      end
      StWbLw: begin
        mem_to_reg = 2'd1;
        reg_write  = 1'b1;
        state_d    = StIf;
      end
      StExI: begin
        alu_src_a = 2'd1;
        alu_src_b = (opcode == OpAndi || opcode == OpOri || opcode == OpXori) ? 3'd3 : 3'd2;
        alu_op    = i_alu_op(opcode);
        state_d   = StWbI;
      end
      StWbI: begin
        reg_write = ~ovf_q;
        exc       = ovf_q;
        state_d   = StIf;
      end
      StExLui: begin
        mem_to_reg = 2'd2;
        reg_write  = 1'b1;
        state_d    = StIf;
      end
      StExBeq, StExBne: begin
        alu_src_a     = 2'd1;
        alu_src_b     = 3'd0;
        alu_op        = AluSub;
        pc_source     = 2'd1;
        pc_write_cond = 1'b1;
        branch        = (state_q == StExBeq);
        state_d       = StIf;
      end
      StExJ: begin
        pc_source = 2'd2;
        pc_write  = 1'b1;
        state_d   = StIf;
      end
      StExJal: begin
        // $31 receives the already-incremented PC on the same edge that loads the target
        pc_source  = 2'd2;
        pc_write   = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd3;
        reg_write  = 1'b1;
        state_d    = StIf;
      end
      StExJr: begin
        pc_source = 2'd3;
        pc_write  = 1'b1;
        state_d   = StIf;
      end
      default: state_d = StIf;
    endcase
  end

  assign bus.IorD          = iord;
  assign bus.IRWrite       = ir_write;
  assign bus.RegDst        = reg_dst;
  assign bus.RegWrite      = reg_write;
  assign bus.MemtoReg      = mem_to_reg;
  assign bus.ALUSrcA       = alu_src_a;
  assign bus.ALUSrcB       = alu_src_b;
  assign bus.PCSource      = pc_source;
  assign bus.PCWrite       = pc_write;
  assign bus.PCWriteCond   = pc_write_cond;
  assign bus.Branch        = branch;
  assign bus.ALU_operation = alu_op;
  assign bus.MemRead       = mem_read;
  assign bus.MemWrite      = mem_write;
  assign bus.CPU_MIO       = cpu_mio;
  assign bus.state         = state_q;
  assign bus.exc           = exc;

endmodule
